// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: receive-side frame controller. Gates uart_rx and assembles
// SOF/CMD/LEN/payload/CHK frames, validating length, XOR checksum and byte gap.
// Ports: clk/reset (sync, active-high), enable, rx_data/rx_finished in from uart_rx,
// rx_enable out to uart_rx, cmd/len/payload hold the last accepted frame,
// frame_valid/frame_error are one-cycle strobes, err_code holds the last error, busy = not IDLE.
module uart_frame_ctrl #(
  parameter int unsigned CLOCK_HZ       = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000,
  parameter int unsigned MAX_LEN        = 8,
  parameter logic [7:0]  SOF            = 8'h02
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           rx_data,
  input  logic                 rx_finished,
  output logic                 rx_enable,
  output logic [7:0]           cmd,
  output logic [3:0]           len,
  output logic [MAX_LEN*8-1:0] payload,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic [1:0]           err_code,
  output logic                 busy
);

  // Gap counter is at least 20 bits wide, wider only if the timeout needs it.
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    LEN_MAX8    = 8'(MAX_LEN);

  // Catch nonsensical parameterisations at elaboration time.
  if (MAX_LEN < 1 || MAX_LEN > 15 || CLOCK_HZ == 0) begin : g_param_check
    $error("uart_frame_ctrl: MAX_LEN must be 1..15 and CLOCK_HZ nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        gap_cnt;
  logic [7:0]           chk_acc;
  logic [7:0]           sh_cmd;
  logic [3:0]           sh_len;
  logic [3:0]           idx;
  logic [MAX_LEN*8-1:0] sh_payload;

  logic       take_byte;
  logic       timeout_hit;
  logic       accept;
  logic       reject;
  logic [1:0] reject_code;

  assign busy = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and decisions. Priority: enable-low abort, then timeout, then
  // the received byte. A byte in the cycle the counter would expire clears
  // timeout_hit, so the byte wins.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    reject      = 1'b0;
    reject_code = 2'b00;
    take_byte   = enable && rx_finished;
    timeout_hit = (state != S_IDLE) && !rx_finished && ((gap_cnt + CW'(1)) == TIMEOUT_LIM);

    if (state != S_IDLE && !enable) begin
      state_nxt = S_IDLE;
    end else if (timeout_hit) begin
      reject      = 1'b1;
      reject_code = 2'b11;
      state_nxt   = S_IDLE;
    end else if (take_byte) begin
      case (state)
        S_IDLE: begin
          if (rx_data == SOF) state_nxt = S_CMD;
        end
        S_CMD: state_nxt = S_LEN;
        S_LEN: begin
          if (rx_data > LEN_MAX8) begin
            reject      = 1'b1;
            reject_code = 2'b01;
            state_nxt   = S_IDLE;
          end else if (rx_data == 8'h00) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if ((idx + 4'd1) == sh_len) state_nxt = S_CHK;
        end
        S_CHK: begin
          if (rx_data == chk_acc) begin
            accept = 1'b1;
          end else begin
            reject      = 1'b1;
            reject_code = 2'b10;
          end
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: shadow assembly, gap counter, published outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_enable   <= 1'b0;
      cmd         <= '0;
      len         <= '0;
      payload     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= 2'b00;
      gap_cnt     <= '0;
      chk_acc     <= '0;
      sh_cmd      <= '0;
      sh_len      <= '0;
      idx         <= '0;
      sh_payload  <= '0;
    end else begin
      rx_enable   <= enable;
      frame_valid <= accept;
      frame_error <= reject;
      if (reject) err_code <= reject_code;

      // Shadow already has unused bytes zeroed, so a straight copy suffices.
      if (accept) begin
        cmd     <= sh_cmd;
        len     <= sh_len;
        payload <= sh_payload;
      end

      if (state == S_IDLE || rx_finished) gap_cnt <= '0;
      else                                gap_cnt <= gap_cnt + CW'(1);

      // take_byte implies enable, so an aborting cycle never lands here.
      if (take_byte && !timeout_hit) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SOF) begin
              sh_payload <= '0;
              idx        <= '0;
              chk_acc    <= '0;
            end
          end
          S_CMD: begin
            sh_cmd  <= rx_data;
            chk_acc <= rx_data;
          end
          S_LEN: begin
            sh_len  <= rx_data[3:0];
            chk_acc <= chk_acc ^ rx_data;
            idx     <= '0;
          end
          S_PAYLOAD: begin
            for (int k = 0; k < int'(MAX_LEN); k++) begin
              if (idx == 4'(k)) sh_payload[k*8 +: 8] <= rx_data;
            end
            chk_acc <= chk_acc ^ rx_data;
            idx     <= idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Testbench for uart_frame_ctrl: scoreboard of expected strobes (kind, cycle,
// register contents) checked by a negedge monitor, plus direct state checks.
module tb_uart_frame_ctrl;
  localparam int TO   = 100;
  localparam int MAXL = 8;
  localparam logic [7:0] SOFB = 8'h02;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [7:0]        rx_data;
  logic              rx_finished;
  logic              rx_enable;
  logic [7:0]        cmd;
  logic [3:0]        len;
  logic [MAXL*8-1:0] payload;
  logic              frame_valid;
  logic              frame_error;
  logic [1:0]        err_code;
  logic              busy;

  uart_frame_ctrl #(
    .CLOCK_HZ(50_000_000), .TIMEOUT_CYCLES(TO), .MAX_LEN(MAXL), .SOF(SOFB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_data(rx_data),
    .rx_finished(rx_finished), .rx_enable(rx_enable), .cmd(cmd), .len(len),
    .payload(payload), .frame_valid(frame_valid), .frame_error(frame_error),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] pl;
    int          due;
  } exp_t;

  exp_t q[$];

  // Reference copy of the published registers.
  logic [7:0]  m_cmd = '0;
  logic [3:0]  m_len = '0;
  logic [63:0] m_pl  = '0;
  logic [1:0]  m_err = '0;
  bit          prev_strobe = 0;
  bit          mon_on = 0;
  int          last_drive_cyc = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (frame_valid || frame_error) begin
        check("strobe_excl", {63'd0, frame_valid & frame_error}, 64'd0);
        check("strobe_b2b", {63'd0, prev_strobe}, 64'd0);
        if (q.size() == 0) begin
          check("strobe_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(e.due));
          check("strobe_kind", {63'd0, frame_error}, {63'd0, e.is_err});
          if (e.is_err) m_err = e.code;
          else begin
            m_cmd = e.cmd; m_len = e.len; m_pl = e.pl;
          end
          check("out_cmd", 64'(cmd), 64'(m_cmd));
          check("out_len", 64'(len), 64'(m_len));
          check("out_payload", payload, m_pl);
          check("out_err_code", 64'(err_code), 64'(m_err));
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        check("strobe_missing", 64'd0, 64'd1);
        void'(q.pop_front());
      end
      prev_strobe = frame_valid || frame_error;
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b, input bit push, input exp_t e);
    exp_t t;
    t = e;
    rx_data = b;
    rx_finished = 1'b1;
    last_drive_cyc = cyc;
    if (push) begin
      t.due = cyc + 1;
      q.push_back(t);
    end
    @(negedge clk);
    rx_finished = 1'b0;
    rx_data = 8'h00;
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.is_err = 0; e.code = 2'b00; e.cmd = '0; e.len = '0; e.pl = '0; e.due = 0;
    return e;
  endfunction

  // Sends a complete frame; the checksum is computed here unless forced.
  task automatic run_frame(input logic [7:0] c, input int n, input logic [119:0] pl,
                           input bit force_chk, input logic [7:0] chk_val);
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] chk;
    exp_t e;
    e = blank();
    send_byte(SOFB, 0, e);
    send_byte(c, 0, e);
    x = c;
    if (n > MAXL) begin
      e.is_err = 1; e.code = 2'b01;
      send_byte(8'(n), 1, e);
      return;
    end
    send_byte(8'(n), 0, e);
    x = x ^ 8'(n);
    for (int k = 0; k < n; k++) begin
      b = pl[8*k +: 8];
      x = x ^ b;
      e.pl[8*k +: 8] = b;
      send_byte(b, 0, e);
    end
    chk = force_chk ? chk_val : x;
    if (chk != x) begin
      e.is_err = 1; e.code = 2'b10;
    end else begin
      e.cmd = c; e.len = 4'(n);
    end
    send_byte(chk, 1, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rx_enable"}, {63'd0, rx_enable}, 64'd0);
    check({pfx, "_cmd"}, 64'(cmd), 64'd0);
    check({pfx, "_len"}, 64'(len), 64'd0);
    check({pfx, "_payload"}, payload, 64'd0);
    check({pfx, "_fv"}, {63'd0, frame_valid}, 64'd0);
    check({pfx, "_fe"}, {63'd0, frame_error}, 64'd0);
    check({pfx, "_err_code"}, 64'(err_code), 64'd0);
    check({pfx, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int c0;
    reset = 1'b1; enable = 1'b1; rx_data = 8'h00; rx_finished = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("rx_enable_after_reset", {63'd0, rx_enable}, 64'd1);
    mon_on = 1;

    // Basic frame: checksum 10^02^31^32 = 11.
    run_frame(8'h10, 2, 120'h3231, 0, 8'h00);
    drain();
    check("busy_after_frame", {63'd0, busy}, 64'd0);
    // The same frame with CHK=03 must be rejected as bad checksum.
    run_frame(8'h10, 2, 120'h3231, 1, 8'h03);
    drain();

    // Length too large; outputs keep the earlier frame, then a new frame.
    run_frame(8'h20, 9, 120'h0, 0, 8'h00);
    drain();
    check("busy_after_badlen", {63'd0, busy}, 64'd0);
    run_frame(8'h21, 8, 120'h8877665544332211, 0, 8'h00);
    drain();

    // Bad checksum: correct value is 50.
    run_frame(8'h10, 1, 120'h41, 1, 8'h00);
    drain();
    check("busy_after_badchk", {63'd0, busy}, 64'd0);

    // Timeout after 100 idle cycles.
    e = blank();
    send_byte(SOFB, 0, e);
    send_byte(8'h10, 0, e);
    check("busy_in_frame", {63'd0, busy}, 64'd1);
    e.is_err = 1; e.code = 2'b11; e.due = last_drive_cyc + TO + 1;
    q.push_back(e);
    drain();
    check("busy_after_timeout", {63'd0, busy}, 64'd0);

    // Byte on gap cycle 100 beats the timeout and the frame completes.
    e = blank();
    send_byte(SOFB, 0, e);
    send_byte(8'h10, 0, e);
    c0 = last_drive_cyc;
    while (cyc < c0 + TO) @(negedge clk);
    send_byte(8'h00, 0, e);
    e.cmd = 8'h10; e.len = 4'd0;
    send_byte(8'h10, 1, e);
    drain();

    // Stray bytes in IDLE, then a zero-length frame back-to-back.
    e = blank();
    send_byte(8'h55, 0, e);
    send_byte(8'hAA, 0, e);
    check("busy_stray", {63'd0, busy}, 64'd0);
    run_frame(8'h10, 0, 120'h0, 0, 8'h00);
    run_frame(8'h33, 3, 120'hC0B0A0, 0, 8'h00);
    drain();

    // Enable low mid-payload aborts silently.
    e = blank();
    send_byte(SOFB, 0, e);
    send_byte(8'h30, 0, e);
    send_byte(8'h03, 0, e);
    send_byte(8'h41, 0, e);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    enable = 1'b1;
    // Enable low together with a byte: abort wins.
    send_byte(SOFB, 0, e);
    send_byte(8'h30, 0, e);
    send_byte(8'h01, 0, e);
    enable = 1'b0;
    send_byte(8'h41, 0, e);
    check("abort_with_byte_busy", {63'd0, busy}, 64'd0);
    // Enable low in IDLE ignores a SOF.
    send_byte(SOFB, 0, e);
    check("idle_disabled_busy", {63'd0, busy}, 64'd0);
    enable = 1'b1;
    @(negedge clk);
    check("abort_cmd_kept", 64'(cmd), 64'(m_cmd));
    check("abort_len_kept", 64'(len), 64'(m_len));
    run_frame(8'h44, 1, 120'h99, 0, 8'h00);
    drain();

    // Reset mid-payload.
    send_byte(SOFB, 0, e);
    send_byte(8'h20, 0, e);
    send_byte(8'h03, 0, e);
    send_byte(8'h41, 0, e);
    reset = 1'b1;
    m_cmd = '0; m_len = '0; m_pl = '0; m_err = '0;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    @(negedge clk);
    check("rx_enable_after_midreset", {63'd0, rx_enable}, 64'd1);
    run_frame(8'h5A, 2, 120'hBEEF, 0, 8'h00);
    drain();

    repeat (3) @(negedge clk);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
